// File: rtl/pwl_pkg.sv
// Shared definitions for the piecewise-linear activation segment search:
// default widths, controller state encoding and a reference breakpoint table.
package pwl_pkg;

   localparam int XDW_DEF     = 16;
   localparam int SEG_NUM_DEF = 8;
   localparam int IDX_W_DEF   = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } pwl_state_t;

   // Reference breakpoints, loaded by benches into the controller table.
   localparam logic [XDW_DEF-1:0] BP_DEFAULT [SEG_NUM_DEF+1] = '{
      16'd0, 16'd256, 16'd512, 16'd1024, 16'd2048,
      16'd4096, 16'd8192, 16'd16384, 16'd32767
   };

endpackage

// File: rtl/biggerAndSmallerOrEqual.sv
// Range comparator: OUT is high when enabled and a < x <= b (unsigned).
// valid is a registered copy of en for callers that need a timed qualifier.
module biggerAndSmallerOrEqual #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [DW-1:0] x,
   output logic          OUT,
   output logic          valid
);

   logic valid_q;
   logic valid_d;

   always_comb begin
      OUT     = en && (x > a) && (x <= b);
      valid_d = en;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
      end
   end

   assign valid = valid_q;

endmodule

// File: rtl/pwl_segment_search_ctrl.sv
// Sequential segment search for the PWL sigmoid/tanh: walks the breakpoint
// table one segment per cycle through one shared range comparator.
module pwl_segment_search_ctrl
   import pwl_pkg::*;
#(
   parameter  int xDW     = XDW_DEF,
   parameter  int SEG_NUM = SEG_NUM_DEF,
   parameter  int IDX_W   = IDX_W_DEF,
   localparam int AW      = $clog2(SEG_NUM + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_we,
   input  logic [AW-1:0]    cfg_addr,
   input  logic [xDW-1:0]   cfg_data,
   output logic             cfg_busy,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [xDW-1:0]   x,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] seg_idx,
   output logic             sign,
   output logic             sat
);

   pwl_state_t       state_q, state_d;
   logic [IDX_W-1:0] k_q, k_d;
   logic [xDW-1:0]   xabs_q, xabs_d;
   logic [IDX_W-1:0] seg_idx_q, seg_idx_d;
   logic             sign_q, sign_d;
   logic             sat_q, sat_d;
   logic             out_valid_q, out_valid_d;
   logic             in_ready_q, in_ready_d;
   logic             cfg_busy_q, cfg_busy_d;
   logic [xDW-1:0]   bp_q [SEG_NUM+1];
   logic [xDW-1:0]   bp_d [SEG_NUM+1];

   logic [AW-1:0]    k_lo;
   logic [AW-1:0]    k_hi;
   logic [xDW-1:0]   bp_lo;
   logic [xDW-1:0]   bp_hi;
   logic             cmp_en;
   logic             cmp_out;
   logic             hit;

   // Magnitude with the most-negative code clamped to the largest positive.
   function automatic logic [xDW-1:0] abs_sat(input logic signed [xDW-1:0] v);
      logic signed [xDW-1:0] neg_v;
      neg_v = -v;
      if (v == {1'b1, {(xDW-1){1'b0}}}) return {1'b0, {(xDW-1){1'b1}}};
      else if (v[xDW-1])                 return neg_v;
      else                               return v;
   endfunction

   assign k_lo   = AW'(k_q);
   assign k_hi   = AW'(k_q) + AW'(1);
   assign bp_lo  = bp_q[k_lo];
   assign bp_hi  = bp_q[k_hi];
   assign cmp_en = (state_q == SEARCH);

   biggerAndSmallerOrEqual #(
      .DW (xDW)
   ) u_cmp (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (cmp_en),
      .a     (bp_lo),
      .b     (bp_hi),
      .x     (xabs_q),
      .OUT   (cmp_out),
      .valid ()
   );

   // A zero magnitude never satisfies a < x, so it is forced into segment 0.
   assign hit = cmp_out || ((k_q == '0) && (xabs_q == '0));

   always_comb begin
      state_q_copy: begin
         state_d   = state_q;
         k_d       = k_q;
         xabs_d    = xabs_q;
         seg_idx_d = seg_idx_q;
         sign_d    = sign_q;
         sat_d     = sat_q;
         bp_d      = bp_q;
      end

      if ((state_q == IDLE) && cfg_we && (cfg_addr <= AW'(SEG_NUM))) begin
         bp_d[cfg_addr] = cfg_data;
      end

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               xabs_d  = abs_sat($signed(x));
               sign_d  = x[xDW-1];
               k_d     = '0;
               state_d = SEARCH;
            end
         end
         SEARCH: begin
            if (hit) begin
               seg_idx_d = k_q;
               sat_d     = 1'b0;
               state_d   = DONE;
            end else if (k_q == IDX_W'(SEG_NUM - 1)) begin
               seg_idx_d = IDX_W'(SEG_NUM - 1);
               sat_d     = 1'b1;
               state_d   = DONE;
            end else begin
               k_d = k_q + IDX_W'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      out_valid_d = (state_d == DONE);
      in_ready_d  = (state_d == IDLE);
      cfg_busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         k_q         <= '0;
         xabs_q      <= '0;
         seg_idx_q   <= '0;
         sign_q      <= 1'b0;
         sat_q       <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         cfg_busy_q  <= 1'b0;
         bp_q        <= '{default: '0};
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         xabs_q      <= xabs_d;
         seg_idx_q   <= seg_idx_d;
         sign_q      <= sign_d;
         sat_q       <= sat_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         cfg_busy_q  <= cfg_busy_d;
         bp_q        <= bp_d;
      end
   end

   assign out_valid = out_valid_q;
   assign in_ready  = in_ready_q;
   assign cfg_busy  = cfg_busy_q;
   assign seg_idx   = seg_idx_q;
   assign sign      = sign_q;
   assign sat       = sat_q;

endmodule

// File: tb/tb_pwl_segment_search_ctrl.sv
// Directed bench for pwl_segment_search_ctrl: hits, boundaries, saturation,
// back-pressure, config gating and asynchronous reset mid-search.
module tb_pwl_segment_search_ctrl;
   import pwl_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        cfg_we;
   logic [3:0]  cfg_addr;
   logic [15:0] cfg_data;
   logic        cfg_busy;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] x;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  seg_idx;
   logic        sign;
   logic        sat;

   int n_cmp = 0;
   int n_err = 0;
   int lat;

   pwl_segment_search_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .cfg_busy  (cfg_busy),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .seg_idx   (seg_idx),
      .sign      (sign),
      .sat       (sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (w >= 50) chk("idle_timeout", {31'd0, in_ready}, 32'd1);
   endtask

   task automatic wr(input logic [3:0] a, input logic [15:0] d);
      wait_idle();
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic prog_default();
      for (int i = 0; i <= 8; i++) wr(4'(i), BP_DEFAULT[i]);
   endtask

   // Returns the number of edges from acceptance to out_valid, -1 on timeout.
   task automatic send(input logic [15:0] xv, input logic we, input logic [3:0] a,
                       input logic [15:0] d, output int l);
      wait_idle();
      x = xv; in_valid = 1'b1;
      cfg_we = we; cfg_addr = a; cfg_data = d;
      @(negedge clk);
      in_valid = 1'b0; cfg_we = 1'b0;
      l = -1;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            l = n;
            break;
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
      in_valid = 1'b0; x = '0; out_ready = 1'b1;
      #12;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
      chk("rst_cfg_busy",  {31'd0, cfg_busy},  32'd0);
      chk("rst_seg_idx",   {29'd0, seg_idx},   32'd0);
      chk("rst_sign_sat",  {30'd0, sign, sat}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      prog_default();

      send(16'd600, 1'b0, 4'd0, 16'd0, lat);
      chk("basic_lat", lat, 32'd3);
      chk("basic_seg", {29'd0, seg_idx}, 32'd2);
      chk("basic_sign_sat", {30'd0, sign, sat}, 32'd0);

      send(16'hFF00, 1'b0, 4'd0, 16'd0, lat);
      chk("neg256_lat", lat, 32'd1);
      chk("neg256_seg", {29'd0, seg_idx}, 32'd0);
      chk("neg256_sign", {31'd0, sign}, 32'd1);

      send(16'd256, 1'b0, 4'd0, 16'd0, lat);
      chk("b256_seg", {29'd0, seg_idx}, 32'd0);
      chk("b256_sign", {31'd0, sign}, 32'd0);

      send(16'd257, 1'b0, 4'd0, 16'd0, lat);
      chk("b257_seg", {29'd0, seg_idx}, 32'd1);
      chk("b257_lat", lat, 32'd2);

      send(16'd0, 1'b0, 4'd0, 16'd0, lat);
      chk("zero_lat", lat, 32'd1);
      chk("zero_seg", {29'd0, seg_idx}, 32'd0);
      chk("zero_sat", {31'd0, sat}, 32'd0);

      wr(4'd8, 16'd20000);
      send(16'h8000, 1'b0, 4'd0, 16'd0, lat);
      chk("sat_lat", lat, 32'd8);
      chk("sat_seg", {29'd0, seg_idx}, 32'd7);
      chk("sat_flag", {31'd0, sat}, 32'd1);
      chk("sat_sign", {31'd0, sign}, 32'd1);
      wr(4'd8, 16'd32767);

      // Back-pressure: result held, no new acceptance while in DONE.
      out_ready = 1'b0;
      send(16'd600, 1'b0, 4'd0, 16'd0, lat);
      chk("bp_lat", lat, 32'd3);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         in_valid = 1'b1; x = 16'd100;
         @(posedge clk); #1;
         chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_hold_seg", {29'd0, seg_idx}, 32'd2);
         chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
      chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      chk("bp_next_busy", {31'd0, cfg_busy}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_next_seg", {29'd0, seg_idx}, 32'd0);

      // Write attempted during SEARCH must be dropped.
      wait_idle();
      x = 16'd300; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      cfg_we = 1'b1; cfg_addr = 4'd2; cfg_data = 16'd0;
      chk("gate_busy", {31'd0, cfg_busy}, 32'd1);
      @(posedge clk); #1;
      chk("gate_mid_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      cfg_we = 1'b0;
      @(posedge clk); #1;
      chk("gate_valid", {31'd0, out_valid}, 32'd1);
      chk("gate_seg", {29'd0, seg_idx}, 32'd1);

      wr(4'd2, 16'd0);
      send(16'd300, 1'b0, 4'd0, 16'd0, lat);
      chk("idle_wr_seg", {29'd0, seg_idx}, 32'd2);
      chk("idle_wr_lat", lat, 32'd3);

      // Write coinciding with acceptance is visible to that search.
      send(16'd300, 1'b1, 4'd2, 16'd512, lat);
      chk("same_cyc_seg", {29'd0, seg_idx}, 32'd1);
      chk("same_cyc_lat", lat, 32'd2);

      // Asynchronous reset at k=3 of a search for -5000.
      wait_idle();
      x = 16'hEC78; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("arst_cfg_busy", {31'd0, cfg_busy}, 32'd0);
      chk("arst_seg_idx", {29'd0, seg_idx}, 32'd0);
      chk("arst_sign", {31'd0, sign}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("arst_no_result", {31'd0, out_valid}, 32'd0);

      send(16'd600, 1'b0, 4'd0, 16'd0, lat);
      chk("cleared_lat", lat, 32'd8);
      chk("cleared_sat", {31'd0, sat}, 32'd1);
      chk("cleared_seg", {29'd0, seg_idx}, 32'd7);

      prog_default();
      send(16'd600, 1'b0, 4'd0, 16'd0, lat);
      chk("reprog_lat", lat, 32'd3);
      chk("reprog_seg", {29'd0, seg_idx}, 32'd2);
      chk("reprog_sat", {31'd0, sat}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
